// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types and constants for the RGB PWM fader: FSM states, default
// geometry and channel indices.
package rgb_pwm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_e;

  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_STEP_PERIODS = 4;

  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
  localparam int NUM_CH = 3;

  // Width of the step prescaler; a single-period step still needs one bit.
  function automatic int step_cnt_width(input int periods);
    return (periods > 1) ? $clog2(periods) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Target-colour handshake between the colour/pattern logic (master) and the
// fader (slave).
interface rgb_pwm_fader_if #(
  parameter int PWM_BITS = rgb_pwm_pkg::DEF_PWM_BITS
);
  logic                in_valid;
  logic                in_ready;
  logic [PWM_BITS-1:0] in_r;
  logic [PWM_BITS-1:0] in_g;
  logic [PWM_BITS-1:0] in_b;

  modport master (output in_valid, output in_r, output in_g, output in_b, input in_ready);
  modport slave  (input in_valid, input in_r, input in_g, input in_b, output in_ready);
endinterface

// File: rtl/rgb_pwm_fader_pwm_channel.sv
// One colour channel: current level and target, one-LSB step toward the
// target on strobe, and the registered PWM compare against the shared counter.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                load,
  input  logic [PWM_BITS-1:0] load_target,
  input  logic                step,
  output logic                match_in,
  output logic                at_target,
  output logic                pwm
);
  localparam logic [PWM_BITS-1:0] LSB = PWM_BITS'(1);

  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] target_r;
  logic [PWM_BITS-1:0] level_step_s;
  logic                pwm_r;

  // Candidate level one LSB closer to the target; never passes the target.
  always_comb begin
    level_step_s = level_r;
    if (level_r < target_r) begin
      level_step_s = level_r + LSB;
    end else if (level_r > target_r) begin
      level_step_s = level_r - LSB;
    end else begin
      level_step_s = level_r;
    end
  end

  // Incoming target already equals the present level (equal-colour request).
  assign match_in = (load_target == level_r);
  // Level would sit on the target once the pending step is applied.
  assign at_target = (level_step_s == target_r);
  assign pwm = pwm_r;

  // Target capture on handshake; level only moves on a step strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_r <= {PWM_BITS{1'b0}};
      level_r  <= {PWM_BITS{1'b0}};
    end else if (load) begin
      target_r <= load_target;
    end else if (step) begin
      level_r <= level_step_s;
    end
  end

  // Registered compare keeps the LED drive free of combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (cnt < level_r);
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader top: free-running PWM counter, fade-step prescaler, IDLE/FADE
// control and the target handshake; three pwm_channel instances do the rest.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int STEP_PERIODS = DEF_STEP_PERIODS
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_fader_if.slave in_if,
  output logic           done,
  output logic           busy,
  output logic           r,
  output logic           g,
  output logic           b
);
  localparam int                  SW        = step_cnt_width(STEP_PERIODS);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};

  fade_state_e         state_r;
  fade_state_e         state_nxt_s;
  logic [PWM_BITS-1:0] cnt_r;
  logic [SW-1:0]       step_cnt_r;
  logic                in_ready_r;
  logic                done_r;
  logic                busy_r;
  logic                done_nxt_s;
  logic                accept_s;
  logic                period_end_s;
  logic                step_s;
  logic                load_s;
  logic [NUM_CH-1:0]   match_in_s;
  logic [NUM_CH-1:0]   at_target_s;
  logic [NUM_CH-1:0]   pwm_s;
  logic [PWM_BITS-1:0] target_in_s [NUM_CH];

  assign target_in_s[CH_R] = in_if.in_r;
  assign target_in_s[CH_G] = in_if.in_g;
  assign target_in_s[CH_B] = in_if.in_b;

  // in_ready_r is only ever high in IDLE, so it doubles as the accept gate.
  assign accept_s     = in_if.in_valid & in_ready_r;
  assign period_end_s = (cnt_r == CNT_MAX);
  assign step_s       = (state_r == FADE) & period_end_s & (step_cnt_r == STEP_LAST);

  assign in_if.in_ready = in_ready_r;
  assign done           = done_r;
  assign busy           = busy_r;
  assign r              = pwm_s[CH_R];
  assign g              = pwm_s[CH_G];
  assign b              = pwm_s[CH_B];

  // PWM period counter: free-running, wraps, never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {PWM_BITS{1'b0}};
    end else begin
      cnt_r <= cnt_r + PWM_BITS'(1);
    end
  end

  // Step prescaler: counts period ends while fading, idles at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_r <= {SW{1'b0}};
    end else if (state_r != FADE) begin
      step_cnt_r <= {SW{1'b0}};
    end else if (period_end_s) begin
      step_cnt_r <= (step_cnt_r == STEP_LAST) ? {SW{1'b0}} : step_cnt_r + SW'(1);
    end
  end

  // Next state, target load and completion pulse.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (&match_in_s) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = FADE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FADE: begin
        if (step_s && (&at_target_s)) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = FADE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
      done_r     <= done_nxt_s;
      busy_r     <= (state_nxt_s == FADE);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cnt         (cnt_r),
      .load        (load_s),
      .load_target (target_in_s[ch]),
      .step        (step_s),
      .match_in    (match_in_s[ch]),
      .at_target   (at_target_s[ch]),
      .pwm         (pwm_s[ch])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader: directed vector table, hand-written
// back-pressure and reset sequences, and randomized targets, all checked
// every cycle against a period-count reference model.
`timescale 1ns/1ps
module tb_rgb_pwm_fader;
  localparam int PB   = 4;
  localparam int SP   = 2;
  localparam int PMAX = (1 << PB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done, busy, r, g, b;

  rgb_pwm_fader_if #(.PWM_BITS(PB)) bus ();

  rgb_pwm_fader #(.PWM_BITS(PB), .STEP_PERIODS(SP)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (bus),
    .done  (done),
    .busy  (busy),
    .r     (r),
    .g     (g),
    .b     (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tr;
    int tg;
    int tb;
    int exp_periods;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: levels are derived from the number of period ends since
  // acceptance, not from any step counter.
  int m_cnt;
  int m_lvl[3];
  int m_start[3];
  int m_tgt[3];
  int m_periods;
  bit m_fading, m_done, m_ready, m_busy;
  bit m_out[3];
  int pe_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_periods = 0;
    m_fading = 1'b0;
    m_done = 1'b0;
    m_ready = 1'b0;
    m_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 0;
      m_start[i] = 0;
      m_tgt[i] = 0;
      m_out[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("r", int'(r), int'(m_out[0]));
    chk("g", int'(g), int'(m_out[1]));
    chk("b", int'(b), int'(m_out[2]));
    chk("done", int'(done), int'(m_done));
    chk("busy", int'(busy), int'(m_busy));
    chk("in_ready", int'(bus.in_ready), int'(m_ready));
  endtask

  // One clock: advance the model with the inputs presented, check at negedge.
  task automatic step_clk();
    int inv[3];
    bit fire, all_eq;
    int k, d, s;
    inv[0] = int'(bus.in_r);
    inv[1] = int'(bus.in_g);
    inv[2] = int'(bus.in_b);
    fire = bus.in_valid && m_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) m_out[i] = (m_cnt < m_lvl[i]);
      m_done = 1'b0;
      if (m_cnt == PMAX) pe_total++;
      if (!m_fading) begin
        if (fire) begin
          all_eq = 1'b1;
          for (int i = 0; i < 3; i++) begin
            m_tgt[i] = inv[i];
            if (inv[i] != m_lvl[i]) all_eq = 1'b0;
          end
          if (all_eq) begin
            m_done = 1'b1;
          end else begin
            m_fading = 1'b1;
            m_periods = 0;
            for (int i = 0; i < 3; i++) m_start[i] = m_lvl[i];
          end
        end
      end else if (m_cnt == PMAX) begin
        m_periods++;
        k = m_periods / SP;
        all_eq = 1'b1;
        for (int i = 0; i < 3; i++) begin
          d = m_tgt[i] - m_start[i];
          s = ((d < 0) ? -d : d);
          if (s > k) s = k;
          m_lvl[i] = m_start[i] + ((d < 0) ? -s : s);
          if (m_lvl[i] != m_tgt[i]) all_eq = 1'b0;
        end
        if (all_eq) begin
          m_fading = 1'b0;
          m_done = 1'b1;
        end
      end
      m_ready = !m_fading;
      m_busy = m_fading;
      m_cnt = (m_cnt + 1) % (PMAX + 1);
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Wait for in_ready, then present the target for exactly one accepting edge.
  task automatic accept(input int tr, input int tg, input int tb);
    int guard = 0;
    while (!bus.in_ready && guard < 2000) begin
      step_clk();
      guard++;
    end
    chk("ready_wait_bound", int'(guard < 2000), 1);
    bus.in_r = PB'(tr);
    bus.in_g = PB'(tg);
    bus.in_b = PB'(tb);
    bus.in_valid = 1'b1;
    step_clk();
    bus.in_valid = 1'b0;
  endtask

  // Run until done; the first noise cycles toggle in_valid with junk data.
  task automatic wait_done(input string name, input int exp_periods, input int pe0,
                           input int noise);
    int guard = 0;
    while (!done && guard < 2000) begin
      if (guard < noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_r = PB'($urandom_range(0, PMAX));
        bus.in_g = PB'($urandom_range(0, PMAX));
        bus.in_b = PB'($urandom_range(0, PMAX));
      end else begin
        bus.in_valid = 1'b0;
      end
      step_clk();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk({name, "_done_seen"}, int'(done), 1);
    chk({name, "_periods"}, pe_total - pe0, exp_periods);
  endtask

  initial begin
    vec_t vecs[8];
    int pe0, guard, done_seen, exp, mx, d;
    int t[3];

    vecs[0] = '{3, 0, 0, 6};
    vecs[1] = '{8, 8, 8, 16};
    vecs[2] = '{10, 5, 8, 6};
    vecs[3] = '{10, 5, 8, 0};
    vecs[4] = '{15, 0, 15, 14};
    vecs[5] = '{0, 15, 0, 30};
    vecs[6] = '{7, 7, 7, 16};
    vecs[7] = '{7, 7, 7, 0};

    bus.in_valid = 1'b0;
    bus.in_r = '0;
    bus.in_g = '0;
    bus.in_b = '0;
    model_reset();

    // Power-on reset held for several clocks.
    @(negedge clk);
    for (int i = 0; i < 5; i++) step_clk();
    rst = 1'b0;
    step_clk();
    chk("ready_after_release", int'(bus.in_ready), 1);

    // Directed vector table, chained from the reset levels.
    for (int v = 0; v < 8; v++) begin
      accept(vecs[v].tr, vecs[v].tg, vecs[v].tb);
      pe0 = pe_total;
      wait_done($sformatf("vec%0d", v), vecs[v].exp_periods, pe0, 0);
      step_clk();
      chk($sformatf("vec%0d_done_one_cycle", v), int'(done), 0);
    end

    // Back-pressure: new target held during the fade, accepted on the done cycle.
    accept(3, 3, 3);
    pe0 = pe_total;
    bus.in_r = PB'(12);
    bus.in_g = PB'(12);
    bus.in_b = PB'(12);
    bus.in_valid = 1'b1;
    guard = 0;
    while (!done && guard < 2000) begin
      step_clk();
      guard++;
    end
    chk("bp_first_periods", pe_total - pe0, 8);
    chk("bp_ready_on_done", int'(bus.in_ready), 1);
    step_clk();
    bus.in_valid = 1'b0;
    pe0 = pe_total;
    chk("bp_no_gap_busy", int'(busy), 1);
    wait_done("bp_second", 18, pe0, 0);

    // Reset in the middle of a fade, while r is high at level 5.
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    step_clk();
    accept(12, 12, 12);
    guard = 0;
    while (!(m_lvl[0] == 5 && m_cnt == 2) && guard < 2000) begin
      step_clk();
      guard++;
    end
    chk("mid_fade_reached", int'(guard < 2000), 1);
    chk("mid_fade_r_high", int'(r), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      if (done) done_seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * (PMAX + 1); i++) begin
      step_clk();
      if (done) done_seen++;
    end
    chk("no_done_after_reset", done_seen, 0);
    accept(2, 0, 1);
    pe0 = pe_total;
    wait_done("post_reset", 2 * SP, pe0, 0);

    // Randomized targets with junk valid pulses early in each fade.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 3; i++) t[i] = $urandom_range(0, PMAX);
      if (n % 5 == 4) begin
        for (int i = 0; i < 3; i++) t[i] = m_lvl[i];
      end
      mx = 0;
      for (int i = 0; i < 3; i++) begin
        d = t[i] - m_lvl[i];
        if (d < 0) d = -d;
        if (d > mx) mx = d;
      end
      exp = mx * SP;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step_clk();
      accept(t[0], t[1], t[2]);
      pe0 = pe_total;
      wait_done($sformatf("rand%0d", n), exp, pe0, (mx > 0) ? 8 : 0);
      step_clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
